// File: rtl/avmm_arb_pkg.sv
// Shared types for the two-client Avalon-MM read/write arbiter.
package avmm_arb_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE0 = 2'd1,
        ISSUE1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] address;
        logic [7:0]  byteenable;
        logic [63:0] writedata;
        logic        is_write;
    } cmd_t;

    // A client raising both read and write is treated as a write.
    function automatic cmd_t make_cmd(
        input logic [63:0] address,
        input logic [7:0]  byteenable,
        input logic [63:0] writedata,
        input logic        write
    );
        cmd_t c;
        c.address    = address;
        c.byteenable = byteenable;
        c.writedata  = writedata;
        c.is_write   = write;
        return c;
    endfunction

endpackage

// File: rtl/rd_owner_fifo.sv
// Records which client owns each outstanding master read, in issue order.
module rd_owner_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset empties the FIFO.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Owner storage; contents are only meaningful while not empty.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avmm_rw_arbiter.sv
// Two-client round-robin arbiter onto one Avalon-MM master, with in-order
// read response routing through an owner FIFO.
//
// state  | meaning
// IDLE   | waiting for an eligible client; winner accepted this cycle
// ISSUE0 | client 0 command on m_*, held until m_waitrequest drops
// ISSUE1 | client 1 command on m_*, held until m_waitrequest drops
module avmm_rw_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int MAX_PENDING = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [63:0] c0_address,
    input  logic [7:0]  c0_byteenable,
    input  logic        c0_read,
    input  logic        c0_write,
    input  logic [63:0] c0_writedata,
    output logic        c0_waitrequest,
    output logic [63:0] c0_readdata,
    output logic        c0_readdatavalid,
    input  logic [63:0] c1_address,
    input  logic [7:0]  c1_byteenable,
    input  logic        c1_read,
    input  logic        c1_write,
    input  logic [63:0] c1_writedata,
    output logic        c1_waitrequest,
    output logic [63:0] c1_readdata,
    output logic        c1_readdatavalid,
    output logic [63:0] m_address,
    output logic [7:0]  m_byteenable,
    output logic        m_read,
    output logic        m_write,
    output logic [63:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [63:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        err_orphan
);

    localparam int               CW       = $clog2(MAX_PENDING) + 1;
    localparam logic [CW-1:0]    PEND_MAX = CW'(MAX_PENDING);

    state_t        state;
    state_t        state_nxt;
    cmd_t          cmd_reg;
    logic          rr_prio;
    logic [CW-1:0] pend_cnt;
    logic          rd_ok;
    logic          elig0;
    logic          elig1;
    logic          gnt0;
    logic          gnt1;
    logic          issuing;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;

    // Reads are held off once MAX_PENDING are outstanding; writes never are.
    assign rd_ok = (pend_cnt < PEND_MAX);
    assign elig0 = c0_write | (c0_read & rd_ok);
    assign elig1 = c1_write | (c1_read & rd_ok);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and grant decode; rr_prio names the client favoured on a tie.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 && elig1) begin
                    gnt0 = ~rr_prio;
                    gnt1 = rr_prio;
                end else begin
                    gnt0 = elig0;
                    gnt1 = elig1;
                end
                if (gnt0)      state_nxt = ISSUE0;
                else if (gnt1) state_nxt = ISSUE1;
            end
            ISSUE0, ISSUE1: begin
                if (!m_waitrequest) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated with resetn so no acceptance can leak out while reset is held.
    assign c0_waitrequest = ~(resetn & gnt0);
    assign c1_waitrequest = ~(resetn & gnt1);

    // Round-robin pointer: after a grant, the other client wins the next tie.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)   rr_prio <= 1'b0;
        else if (gnt0) rr_prio <= 1'b1;
        else if (gnt1) rr_prio <= 1'b0;
    end

    // Capture the winner's command; it stays stable for the whole ISSUE state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cmd_reg <= '0;
        end else if (gnt0) begin
            cmd_reg <= make_cmd(c0_address, c0_byteenable, c0_writedata, c0_write);
        end else if (gnt1) begin
            cmd_reg <= make_cmd(c1_address, c1_byteenable, c1_writedata, c1_write);
        end
    end

    assign issuing      = (state == ISSUE0) || (state == ISSUE1);
    assign m_read       = issuing & ~cmd_reg.is_write;
    assign m_write      = issuing & cmd_reg.is_write;
    assign m_address    = cmd_reg.address;
    assign m_byteenable = cmd_reg.byteenable;
    assign m_writedata  = cmd_reg.writedata;

    assign fifo_push = m_read & ~m_waitrequest & ~fifo_full;
    assign fifo_pop  = m_readdatavalid & ~fifo_empty;

    rd_owner_fifo #(
        .DEPTH(MAX_PENDING)
    ) u_owner_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (fifo_push),
        .push_data(state == ISSUE1),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Outstanding read count; saturating guards keep it from ever wrapping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_cnt <= '0;
        end else begin
            case ({fifo_push, fifo_pop})
                2'b10: if (pend_cnt != PEND_MAX) pend_cnt <= pend_cnt + CW'(1);
                2'b01: if (pend_cnt != '0)       pend_cnt <= pend_cnt - CW'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // A response with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                            err_orphan <= 1'b0;
        else if (m_readdatavalid && fifo_empty) err_orphan <= 1'b1;
    end

    assign c0_readdata      = m_readdata;
    assign c1_readdata      = m_readdata;
    assign c0_readdatavalid = m_readdatavalid & ~fifo_empty & ~fifo_head;
    assign c1_readdatavalid = m_readdatavalid & ~fifo_empty & fifo_head;

endmodule

// File: doc/avmm_rw_arbiter.md
AVMM_RW_ARBITER -- requirements
Module: avmm_rw_arbiter

Interface
REQ-001 The block SHALL use one clock, clock, and an asynchronous active-low reset, resetn.
REQ-002 Parameter MAX_PENDING, default 8, SHALL set the maximum number of outstanding master reads (power of 2, 2..64).
REQ-003 Ports SHALL be as follows, with clock and reset first; c<k> denotes client k, k in {0,1}, and each c<k> line covers both clients:
- clock  in  1  kernel clock
- resetn  in  1  async active-low reset
- c<k>_address  in  64  byte address
- c<k>_byteenable  in  8  byte lanes
- c<k>_read  in  1  read request
- c<k>_write  in  1  write request
- c<k>_writedata  in  64  write data
- c<k>_waitrequest  out  1  request not accepted this cycle
- c<k>_readdata  out  64  read response data
- c<k>_readdatavalid  out  1  response for client k
- m_address / m_byteenable / m_read / m_write / m_writedata  out  64/8/1/1/64  shared avmm_0_rw-style master command
- m_waitrequest  in  1  slave stall
- m_readdata  in  64  response data
- m_readdatavalid  in  1  response valid, in request order
- err_orphan  out  1  sticky: response arrived with no read pending

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE0 and ISSUE1.
REQ-005 In IDLE, a client is eligible if (read or write) is asserted, and a read is eligible only when pend_cnt < MAX_PENDING.
REQ-006 With one eligible client, it SHALL win; with both eligible, the client not granted most recently SHALL win (client 0 after reset); rr pointer updates on each grant.
REQ-007 The winner's c<k>_waitrequest SHALL be 0 in that IDLE cycle (acceptance), its command SHALL be registered into m_*, and the FSM SHALL go to ISSUE<k>.
REQ-008 c<k>_waitrequest SHALL be 1 in every other cycle and state.
REQ-009 In ISSUE<k>, m_read/m_write and all m_* fields SHALL hold stable until a cycle with m_waitrequest=0, then m_read=m_write=0 and FSM -> IDLE next cycle.
REQ-010 Latency SHALL be: accept in cycle N, m_read/m_write first high in N+1; peak throughput one command per 2 cycles.
REQ-011 A client asserting both read and write SHALL be treated as a write; the read is ignored.
REQ-012 On master read acceptance (m_read & !m_waitrequest), the owner id k SHALL be pushed into the owner FIFO and pend_cnt incremented.
REQ-013 On m_readdatavalid, the FIFO head SHALL be popped and pend_cnt decremented; simultaneous push and pop leave pend_cnt unchanged.
REQ-014 c0_readdata and c1_readdata SHALL both equal m_readdata combinationally; c<k>_readdatavalid = m_readdatavalid & (head==k) & FIFO non-empty, with zero added latency.
REQ-015 m_readdatavalid with an empty FIFO SHALL be dropped (no client valid), set err_orphan until reset, and leave pend_cnt at 0.
REQ-016 When pend_cnt==MAX_PENDING, reads SHALL be blocked while writes remain grantable; a pop in the same cycle does not unblock until the next cycle.
REQ-017 pend_cnt SHALL be $clog2(MAX_PENDING)+1 bits wide and SHALL never wrap.

Reset
REQ-018 Assertion of resetn=0 SHALL asynchronously force state IDLE, m_read=m_write=0, m_address/m_byteenable/m_writedata=0, c<k>_waitrequest=1, c<k>_readdatavalid=0, FIFO empty, pend_cnt=0, rr pointer=client 0, err_orphan=0.
REQ-019 On reset mid-transaction, in-flight commands and pending ownership SHALL be discarded; later responses are orphans per REQ-015.
REQ-020 The first grant SHALL be possible in the first clock edge after resetn deasserts synchronously.

Structure
REQ-021 Package avmm_arb_pkg SHALL hold the state enum, the NUM_CLIENTS=2 constant, and a command struct (address, byteenable, writedata, is_write).
REQ-022 Sub-module rd_owner_fifo (depth MAX_PENDING, 1-bit entries, push/pop/full/empty/head) SHALL track response ownership.

Verification
REQ-023 Single read: c0 read 0x100 -> c0_waitrequest=0 in cycle N, m_read/m_address=0x100 in N+1; m_readdatavalid with 0xDEAD -> c0_readdatavalid=1, c0_readdata=0xDEAD, c1_readdatavalid=0.
REQ-024 Contention: c0 and c1 both write continuously -> grants alternate c0,c1,c0,c1, one per 2 cycles with m_waitrequest=0.
REQ-025 Stall: m_waitrequest=1 for 5 cycles in ISSUE1 -> m_* stable for all 5 cycles, with no further client acceptances.
REQ-026 Limit: MAX_PENDING=8 with no responses, c0 issues 9 reads -> 9th held (waitrequest=1) while a c1 write is accepted; one response then releases the 9th read.
REQ-027 Ordering/orphan: reads c1,c0,c1 then 3 responses -> valids routed c1,c0,c1; a 4th response sets err_orphan=1 with no client valid.
REQ-028 Reset during ISSUE0 with 3 reads pending -> m_read=0 and pend_cnt=0 immediately, and the next response sets err_orphan.
